// File: rtl/aes_key_expand.sv
// AES-128 round-key generator: streams round keys 0..NR over a valid/ready handshake,
// computing each next key in a single cycle from the key currently on display.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  localparam logic [7:0] TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign c = TABLE[a];
endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   idx_reg, idx_next;
  logic [7:0]   rcon_reg, rcon_next;
  logic         done_reg, done_next;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word, sub_word, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic         accept;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      sbox u_sbox (
        .a (rot_word[8*gi +: 8]),
        .c (sub_word[8*gi +: 8])
      );
    end
  endgenerate

  assign t_word = sub_word ^ {rcon_reg, 24'h0};
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  assign accept = (state_reg == EMIT) && rk_ready;

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    idx_next   = idx_reg;
    rcon_next  = rcon_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          key_next   = key_in;
          idx_next   = 4'd0;
          rcon_next  = 8'h01;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (accept) begin
          if (idx_reg == LAST_IDX) begin
            // Clearing the key on exit keeps rk_out at zero throughout IDLE.
            state_next = IDLE;
            key_next   = '0;
            idx_next   = 4'd0;
            rcon_next  = 8'h01;
            done_next  = 1'b1;
          end else begin
            key_next  = {n0, n1, n2, n3};
            idx_next  = idx_reg + 4'd1;
            rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= 4'd0;
      rcon_reg  <= 8'h01;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      idx_reg   <= idx_next;
      rcon_reg  <= rcon_next;
      done_reg  <= done_next;
    end
  end

  assign rk_valid = (state_reg == EMIT);
  assign busy     = (state_reg == EMIT);
  assign rk_out   = key_reg;
  assign rk_idx   = idx_reg;
  assign done     = done_reg;
endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized bench for aes_key_expand against a GF(2^8)-arithmetic reference of the
// AES-128 key schedule, plus FIPS-197 and all-zero known vectors.

module tb_aes_key_expand;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key_in;
  logic         rk_valid, busy, done;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_rk [0:NR];
  logic [127:0] obs    [0:NR];

  aes_key_expand #(.NR(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: S-box derived from the field inverse and affine map, not a table.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_ref(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*NR+4; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {ref_sbox(tmp[31:24]), ref_sbox(tmp[23:16]), ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full expansion. rst_at >= 0 aborts with reset when that index is on display.
  task automatic expand(input logic [127:0] key, input bit rand_ready, input bit poke,
                        input int rst_at, input bit pre_started, input bit chain,
                        input logic [127:0] next_key);
    int idx = 0;
    int cyc = 1;
    bit rdy = 1'b1;
    logic [127:0] prev_out = '0;
    build_ref(key);
    if (!pre_started) begin
      @(negedge clk);
      start  = 1'b1;
      key_in = key;
    end
    @(negedge clk);
    start  = 1'b0;
    key_in = rand128();
    for (int it = 0; it < 400; it++) begin
      if (idx == NR + 1) begin
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("valid_after", rk_valid, 0);
        check("out_cleared", rk_out, 0);
        if (!rand_ready) check("done_latency", cyc, 12);
        $display("expansion key=%h done after %0d cycles", key, cyc);
        if (chain) begin
          start  = 1'b1;
          key_in = next_key;
        end else begin
          @(negedge clk);
          check("done_single", done, 0);
        end
        return;
      end
      check("valid", rk_valid, 1);
      check("busy", busy, 1);
      check("no_early_done", done, 0);
      check("idx", rk_idx, idx);
      check("round_key", rk_out, exp_rk[idx]);
      if (!rdy) check("held_key", rk_out, prev_out);
      obs[idx] = rk_out;
      prev_out = rk_out;
      if (rst_at == idx) begin
        rk_ready = 1'($urandom_range(0, 1));
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", rk_idx, 0);
        check("rst_out", rk_out, 0);
        check("rst_no_done", done, 0);
        @(negedge clk);
        check("rst_no_done_late", done, 0);
        $display("expansion key=%h aborted by reset at idx %0d", key, idx);
        return;
      end
      if (poke && idx == 3) begin
        start  = 1'b1;
        key_in = rand128();
      end else begin
        start = 1'b0;
      end
      rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    check("timeout", 0, 1);
  endtask

  initial begin
    logic [127:0] k1, k2;
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", rk_valid, 0);
    check("reset_out", rk_out, 0);
    check("reset_idx", rk_idx, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // start together with rst: rst wins.
    start = 1'b1; key_in = rand128();
    @(negedge clk);
    check("rst_beats_start", rk_valid, 0);
    rst = 1'b0; start = 1'b0;

    expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0);
    check("fips_idx0", obs[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("fips_idx1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_idx10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    expand(128'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0);
    check("zero_idx1", obs[1], 128'h62636363626363636263636362636363);
    check("zero_idx10", obs[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b0, -1, 1'b0, 1'b0, '0);
    check("bp_fips_idx1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("bp_fips_idx10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    expand(rand128(), 1'b1, 1'b1, -1, 1'b0, 1'b0, '0);

    k1 = rand128();
    expand(k1, 1'b0, 1'b0, 5, 1'b0, 1'b0, '0);
    expand(k1, 1'b1, 1'b0, -1, 1'b0, 1'b0, '0);

    k1 = rand128();
    k2 = rand128();
    expand(k1, 1'b0, 1'b0, -1, 1'b0, 1'b1, k2);
    expand(k2, 1'b1, 1'b0, -1, 1'b1, 1'b0, '0);

    for (int n = 0; n < 4; n++) expand(rand128(), 1'b1, 1'b0, -1, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
